twi_regfile: RTL and testbench
==============================

Name: twi_regfile

Overview:
- Parametrised successor to the single-byte twi_slave: one I2C slave address exposes a bank of NUM_REGS 8-bit registers behind a register pointer, with auto-increment.
- SCL/SDA are oversampled in the system clock domain (clk, the 16 MHz PLL output) instead of clocking logic from SCL.
- Sits in top beside the SB_IO SDA block. Open-drain drive only: sda_out_en=1 pulls the line low.

Parameters:
- ADDR, 7'h33, 7-bit slave address.
- NUM_REGS, 4, register count, 2..256.
- RO_MASK, {NUM_REGS{1'b0}}, bit i=1 makes register i read-only.
- INIT_VAL, 8'h00, reset value of every writable register.

Ports:
- clk  in  1  system clock; all logic on posedge.
- resetn  in  1  synchronous, active-low reset.
- scl_in  in  1  raw SCL pin, asynchronous.
- sda_in  in  1  raw SDA pin (SB_IO D_IN_0), asynchronous.
- sda_out_en  out  1  1 = drive SDA low (SB_IO D_OUT_0 tied 0).
- reg_out  out  8*NUM_REGS  register contents, flattened, reg i at [8i+7:8i].
- reg_in  in  8*NUM_REGS  read data for read-only registers, same packing.
- wr_stb  out  1  one-cycle pulse per committed register write.
- wr_idx  out  8  index of the register written, valid with wr_stb.
- busy  out  1  high from START until STOP or address NACK.

Behaviour:
- Reset (resetn=0 at posedge clk): state IDLE, sda_out_en=0, busy=0, wr_stb=0, wr_idx=0, pointer=0, writable regs=INIT_VAL. Reset mid-transfer aborts immediately and releases SDA on the same edge.
- Input path: 2-flop synchroniser per line, then a previous-sample register. Edge/condition detection uses the synchronised samples.
- START: SDA 1->0 while SCL=1. STOP: SDA 0->1 while SCL=1. Both are recognised in any state.
  - START (including repeated START) -> ADDR, bit count 0.
  - STOP -> IDLE.
- Data is sampled on SCL rising edges. SDA drive changes only on the first clk after an SCL falling edge.
- States:
  - IDLE: no drive.
  - ADDR: shift 8 bits MSB-first.
    - addr[7:1]==ADDR -> ADDR_ACK.
    - Otherwise -> IDLE with no ACK; busy drops.
  - ADDR_ACK: drive low for one SCL pulse.
    - R/W=0 -> PTR.
    - R/W=1 -> load shift register from the pointed register -> RDATA.
  - PTR: 8 bits.
    - Value < NUM_REGS: ACK, pointer := value.
    - Value >= NUM_REGS: NACK, pointer unchanged, -> IDLE.
  - PTR_ACK then WDATA: 8 bits, then ACK (always).
    - Writable register: commit on the ACK SCL rising edge; wr_stb=1 for exactly one clk with wr_idx=pointer.
    - RO register: data discarded, no wr_stb.
    - Pointer increments after every data byte.
  - RDATA: drive sda_out_en=~bit for 8 bits.
    - Source is reg_in[i] if RO_MASK[i]=1, else the internal reg i.
    - Source is captured at ADDR_ACK or on the previous master ACK.
  - RACK: release SDA, sample master ACK.
    - ACK(0) -> pointer+1, reload -> RDATA.
    - NACK(1) -> IDLE (SDA released, wait for STOP/START).
- Pointer wrap: NUM_REGS-1 -> 0, for both reads and writes.
- The pointer persists across transactions. A write of only the pointer byte, then a repeated-START read, reads from that pointer.
- Minimum clk/SCL ratio is 16 (16 MHz vs 400 kHz is OK). Behaviour below that ratio is unspecified.
- START and an SCL edge cannot coincide on the bus. If SDA and SCL change in the same sample, START/STOP detection takes priority.

Optional Feature:
- TWI_GLITCH_FILTER_EN
  - Defined: each synchronised line passes through a 3-sample majority filter. This adds 2 clk of latency, and pulses ≤1 clk wide are suppressed.
  - Undefined: no filter; the synchroniser output is used directly, and 1-clk glitches may be seen as edges.
  - External protocol behaviour is otherwise identical.

Test Plan:
- Write 0x33W, ptr 0x01, data 0xA5, 0x5A, STOP:
  - All bytes ACKed.
  - reg_out[15:8]=0xA5, reg_out[23:16]=0x5A.
  - Two wr_stb pulses with wr_idx=1 then 2.
- Write ptr 0x03, data 0x11, 0x22: reg3=0x11, wrap, reg0=0x22.
- Read with RO_MASK=4'b0100, reg_in[23:16]=0xC3:
  - ptr 0x02, repeated START, 0x33R, master ACK, then NACK.
  - Returns 0xC3 then reg3's value; SDA released after the NACK.
- Wrong address 0x44W: no ACK, sda_out_en stays 0, busy drops. Pointer out of range (0x07): NACKed, pointer unchanged.
- Reset mid-read while driving a 0 bit:
  - sda_out_en=0 on that edge, regs=0x00.
  - A subsequent 0x33W transaction works.
- 1-clk SDA glitch while SCL high:
  - With TWI_GLITCH_FILTER_EN: transfer unaffected.
  - Without it: a spurious STOP/START is detected.

Source files
------------

// File: rtl/twi_regfile.sv
// twi_regfile: I2C slave with one 7-bit address and a bank of NUM_REGS byte
// registers behind an auto-incrementing register pointer. SCL/SDA are
// oversampled in the clk domain; SDA is driven open-drain via sda_out_en.
// Optional build macro: TWI_GLITCH_FILTER_EN adds a 3-sample majority filter
// on each synchronised line (2 clk extra latency, 1-clk pulses suppressed).
module twi_regfile #(
    parameter logic [6:0]          ADDR     = 7'h33,
    parameter int                  NUM_REGS = 4,
    parameter logic [NUM_REGS-1:0] RO_MASK  = {NUM_REGS{1'b0}},
    parameter logic [7:0]          INIT_VAL = 8'h00
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    scl_in,
    input  logic                    sda_in,
    output logic                    sda_out_en,
    output logic [8*NUM_REGS-1:0]   reg_out,
    input  logic [8*NUM_REGS-1:0]   reg_in,
    output logic                    wr_stb,
    output logic [7:0]              wr_idx,
    output logic                    busy
);
    localparam int         PW       = $clog2(NUM_REGS);
    localparam logic [8:0] NREGS9   = 9'(NUM_REGS);
    localparam logic [7:0] LAST_IDX = 8'(NUM_REGS - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RACK
    } state_t;

    logic [1:0] scl_sync_q, sda_sync_q;
    logic       scl_line, sda_line;
    logic       scl_prev_q, sda_prev_q;

    state_t     state_q;
    logic [7:0] shift_q;
    logic [3:0] cnt_q;
    logic [7:0] ptr_q;
    logic       rw_q;
    logic       drv_q;
    logic       oe_q;
    logic       busy_q;
    logic       wr_stb_q;
    logic [7:0] wr_idx_q;
    logic [7:0] regs_q [NUM_REGS];
    logic [7:0] src_w  [NUM_REGS];

    logic [7:0] ptr_inc_d;
    logic [7:0] rx_byte_d;
    logic       start_det, stop_det, scl_rise, scl_fall;

    // Two-flop synchronisers; lines idle high so reset them to 1.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_in};
            sda_sync_q <= {sda_sync_q[0], sda_in};
        end
    end

`ifdef TWI_GLITCH_FILTER_EN
    logic [1:0] scl_hist_q, sda_hist_q;
    logic       scl_filt_q, sda_filt_q;

    // Majority of the last three synchronised samples, registered.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            scl_hist_q <= 2'b11;
            sda_hist_q <= 2'b11;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
        end else begin
            scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
            sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
            scl_filt_q <= (scl_sync_q[1] & scl_hist_q[0]) | (scl_sync_q[1] & scl_hist_q[1])
                        | (scl_hist_q[0] & scl_hist_q[1]);
            sda_filt_q <= (sda_sync_q[1] & sda_hist_q[0]) | (sda_sync_q[1] & sda_hist_q[1])
                        | (sda_hist_q[0] & sda_hist_q[1]);
        end
    end

    assign scl_line = scl_filt_q;
    assign sda_line = sda_filt_q;
`else
    assign scl_line = scl_sync_q[1];
    assign sda_line = sda_sync_q[1];
`endif

    // Previous-sample registers for edge and START/STOP detection.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_prev_q <= scl_line;
            sda_prev_q <= sda_line;
        end
    end

    assign start_det = scl_line & scl_prev_q & sda_prev_q & ~sda_line;
    assign stop_det  = scl_line & scl_prev_q & ~sda_prev_q & sda_line;
    assign scl_rise  = scl_line & ~scl_prev_q;
    assign scl_fall  = ~scl_line & scl_prev_q;
    assign ptr_inc_d = (ptr_q == LAST_IDX) ? 8'd0 : ptr_q + 8'd1;
    assign rx_byte_d = {shift_q[6:0], sda_line};

    // Read-source mux per register and flattened register output.
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs
        assign src_w[gi]            = RO_MASK[gi] ? reg_in[8*gi +: 8] : regs_q[gi];
        assign reg_out[8*gi +: 8]   = regs_q[gi];
    end

    // Protocol FSM: shifts on SCL rise, changes SDA drive only after SCL fall.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            shift_q  <= 8'd0;
            cnt_q    <= 4'd0;
            ptr_q    <= 8'd0;
            rw_q     <= 1'b0;
            drv_q    <= 1'b0;
            oe_q     <= 1'b0;
            busy_q   <= 1'b0;
            wr_stb_q <= 1'b0;
            wr_idx_q <= 8'd0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= INIT_VAL;
        end else begin
            wr_stb_q <= 1'b0;
            if (start_det) begin
                state_q <= S_ADDR;
                cnt_q   <= 4'd0;
                drv_q   <= 1'b0;
                oe_q    <= 1'b0;
                busy_q  <= 1'b1;
            end else if (stop_det) begin
                state_q <= S_IDLE;
                drv_q   <= 1'b0;
                oe_q    <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_ADDR: if (scl_rise) begin
                        shift_q <= rx_byte_d;
                        cnt_q   <= cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            if (shift_q[6:0] == ADDR) begin
                                rw_q    <= sda_line;
                                state_q <= S_ADDR_ACK;
                            end else begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                    S_ADDR_ACK: if (scl_fall) begin
                        if (!drv_q) begin
                            drv_q <= 1'b1;
                            oe_q  <= 1'b1;
                        end else begin
                            drv_q <= 1'b0;
                            cnt_q <= 4'd0;
                            if (rw_q) begin
                                shift_q <= src_w[ptr_q[PW-1:0]];
                                oe_q    <= ~src_w[ptr_q[PW-1:0]][7];
                                state_q <= S_RDATA;
                            end else begin
                                oe_q    <= 1'b0;
                                state_q <= S_PTR;
                            end
                        end
                    end
                    S_PTR: if (scl_rise) begin
                        shift_q <= rx_byte_d;
                        cnt_q   <= cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            if ({1'b0, rx_byte_d} < NREGS9) begin
                                ptr_q   <= rx_byte_d;
                                state_q <= S_PTR_ACK;
                            end else begin
                                state_q <= S_IDLE;
                            end
                        end
                    end
                    S_PTR_ACK, S_WDATA_ACK: begin
                        // Commit on the ACK clock's rising edge; the pointer advances
                        // after every data byte, even for read-only targets.
                        if (state_q == S_WDATA_ACK && scl_rise && drv_q) begin
                            if (!RO_MASK[ptr_q[PW-1:0]]) begin
                                regs_q[ptr_q[PW-1:0]] <= shift_q;
                                wr_stb_q              <= 1'b1;
                                wr_idx_q              <= ptr_q;
                            end
                            ptr_q <= ptr_inc_d;
                        end
                        if (scl_fall) begin
                            if (!drv_q) begin
                                drv_q <= 1'b1;
                                oe_q  <= 1'b1;
                            end else begin
                                drv_q   <= 1'b0;
                                oe_q    <= 1'b0;
                                cnt_q   <= 4'd0;
                                state_q <= S_WDATA;
                            end
                        end
                    end
                    S_WDATA: if (scl_rise) begin
                        shift_q <= rx_byte_d;
                        cnt_q   <= cnt_q + 4'd1;
                        if (cnt_q == 4'd7) state_q <= S_WDATA_ACK;
                    end
                    S_RDATA: begin
                        if (scl_rise) cnt_q <= cnt_q + 4'd1;
                        if (scl_fall) begin
                            if (cnt_q == 4'd8) begin
                                oe_q    <= 1'b0;
                                drv_q   <= 1'b0;
                                state_q <= S_RACK;
                            end else begin
                                shift_q <= {shift_q[6:0], 1'b0};
                                oe_q    <= ~shift_q[6];
                            end
                        end
                    end
                    S_RACK: begin
                        if (scl_rise && !drv_q) begin
                            if (!sda_line) begin
                                ptr_q   <= ptr_inc_d;
                                shift_q <= src_w[ptr_inc_d[PW-1:0]];
                                drv_q   <= 1'b1;
                            end else begin
                                state_q <= S_IDLE;
                            end
                        end
                        if (scl_fall && drv_q) begin
                            oe_q    <= ~shift_q[7];
                            drv_q   <= 1'b0;
                            cnt_q   <= 4'd0;
                            state_q <= S_RDATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign sda_out_en = oe_q;
    assign busy       = busy_q;
    assign wr_stb     = wr_stb_q;
    assign wr_idx     = wr_idx_q;
endmodule

// File: tb/tb_twi_regfile.sv
// Bench for twi_regfile: an I2C master model drives SCL/SDA (open-drain bus),
// a table of directed transactions with hand-computed results, hand-written
// reset/glitch sequences, and randomised transactions against a register model.
module tb_twi_regfile;
    localparam int         Q  = 6;          // clk cycles per quarter SCL period
    localparam logic [3:0] RO = 4'b0100;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        scl = 1'b1;
    logic        sda_m = 1'b1;
    logic        sda_bus;
    logic        sda_out_en, wr_stb, busy;
    logic [31:0] reg_out;
    logic [31:0] reg_in = 32'h5EC37D9A;
    logic [7:0]  wr_idx;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] stb_q[$];
    logic [7:0] exp_stb[$];

    assign sda_bus = sda_m & ~sda_out_en;

    twi_regfile #(.ADDR(7'h33), .NUM_REGS(4), .RO_MASK(RO), .INIT_VAL(8'h00)) dut (
        .clk(clk), .resetn(resetn), .scl_in(scl), .sda_in(sda_bus),
        .sda_out_en(sda_out_en), .reg_out(reg_out), .reg_in(reg_in),
        .wr_stb(wr_stb), .wr_idx(wr_idx), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (wr_stb) stb_q.push_back(wr_idx);

    initial begin
        repeat (90000) @(negedge clk);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic compare_stb(input string tag);
        check({tag, "_stb_count"}, 32'(stb_q.size()), 32'(exp_stb.size()));
        for (int i = 0; i < exp_stb.size(); i++)
            check({tag, "_stb_idx"}, (i < stb_q.size()) ? 32'(stb_q[i]) : 32'hFFFF_FFFF,
                  32'(exp_stb[i]));
    endtask

    task automatic wait_q;
        repeat (Q) @(negedge clk);
    endtask

    task automatic xfer_bit(input logic tx, output logic rx);
        sda_m = tx; wait_q;
        scl = 1'b1; wait_q;
        rx = sda_bus; wait_q;
        scl = 1'b0; wait_q;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic d;
        for (int i = 7; i >= 0; i--) xfer_bit(b[i], d);
        xfer_bit(1'b1, ack);
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] b);
        logic d;
        for (int i = 7; i >= 0; i--) begin
            xfer_bit(1'b1, d);
            b[i] = d;
        end
        xfer_bit(mack, d);
    endtask

    task automatic i2c_start;
        sda_m = 1'b1; wait_q;
        scl = 1'b1; wait_q;
        sda_m = 1'b0; wait_q;
        scl = 1'b0; wait_q;
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0; wait_q;
        scl = 1'b1; wait_q;
        sda_m = 1'b1; wait_q;
    endtask

    task automatic do_write(input logic [6:0] a, input logic [7:0] p, input int n,
                            input logic [31:0] d, output logic aack, output logic pack,
                            output logic [3:0] dack, output logic busy_a);
        logic k;
        pack = 1'b1;
        dack = 4'b0;
        i2c_start;
        send_byte({a, 1'b0}, aack);
        busy_a = busy;
        if (!aack) begin
            send_byte(p, pack);
            if (!pack)
                for (int i = 0; i < n; i++) begin
                    send_byte(d[8*i +: 8], k);
                    dack[i] = k;
                end
        end
        i2c_stop;
    endtask

    task automatic do_read(input logic set_ptr, input logic [7:0] p, input int n,
                           output logic [1:0] acks, output logic [31:0] rd, output logic oe_after);
        logic a;
        logic [7:0] b;
        acks = 2'b00;
        rd   = 32'd0;
        i2c_start;
        if (set_ptr) begin
            send_byte(8'h66, a); acks[0] = a;
            send_byte(p, a);     acks[1] = a;
            i2c_start;
        end
        send_byte(8'h67, a);
        acks[0] = acks[0] | a;
        for (int i = 0; i < n; i++) begin
            recv_byte(i == n - 1, b);
            rd[8*i +: 8] = b;
        end
        oe_after = sda_out_en;
        i2c_stop;
    endtask

    typedef struct {
        int          kind;   // 0 write, 1 set pointer + repeated-START read, 2 read at pointer
        logic [6:0]  addr;
        logic [7:0]  ptr;
        int          n;
        logic [31:0] wd;
        logic        aack;
        logic        pack;
        logic [31:0] rd;
        logic [31:0] regs;
        int          nstb;
        logic [15:0] stb;
    } vec_t;

    function automatic vec_t mk(int kind, logic [6:0] addr, logic [7:0] ptr, int n,
                                logic [31:0] wd, logic aack, logic pack, logic [31:0] rd,
                                logic [31:0] regs, int nstb, logic [15:0] stb);
        vec_t v;
        v.kind = kind; v.addr = addr; v.ptr = ptr; v.n = n; v.wd = wd;
        v.aack = aack; v.pack = pack; v.rd = rd; v.regs = regs; v.nstb = nstb; v.stb = stb;
        return v;
    endfunction

    initial begin
        vec_t        vec[10];
        logic        aack, pack, busy_a, oe_after, ack, dummy;
        logic [3:0]  dack;
        logic [1:0]  acks;
        logic [31:0] rd, d;
        logic [7:0]  m_regs[4];
        logic [7:0]  p8;
        int          m_ptr, kind, n;
        logic [31:0] exp_rd;

        vec[0] = mk(0, 7'h33, 8'h01, 2, 32'h5AA5, 0, 0, 0, 32'h0000A500, 1, 16'h0001);
        vec[1] = mk(0, 7'h33, 8'h03, 2, 32'h2211, 0, 0, 0, 32'h1100A522, 2, 16'h0003);
        vec[2] = mk(1, 7'h33, 8'h02, 2, 0,        0, 0, 32'h11C3, 32'h1100A522, 0, 0);
        vec[3] = mk(0, 7'h33, 8'h07, 0, 0,        0, 1, 0, 32'h1100A522, 0, 0);
        vec[4] = mk(2, 7'h33, 8'h00, 1, 0,        0, 0, 32'h11, 32'h1100A522, 0, 0);
        vec[5] = mk(0, 7'h44, 8'h00, 1, 32'hFF,   1, 1, 0, 32'h1100A522, 0, 0);
        vec[6] = mk(0, 7'h33, 8'h00, 1, 32'h3C,   0, 0, 0, 32'h1100A53C, 1, 16'h0000);
        vec[7] = mk(2, 7'h33, 8'h00, 2, 0,        0, 0, 32'hC3A5, 32'h1100A53C, 0, 0);
        vec[8] = mk(0, 7'h33, 8'h03, 0, 0,        0, 0, 0, 32'h1100A53C, 0, 0);
        vec[9] = mk(2, 7'h33, 8'h00, 2, 0,        0, 0, 32'h3C11, 32'h1100A53C, 0, 0);
        // Second stb index for vec[1] is register 0 (wrap).

        // Reset state
        repeat (4) @(negedge clk);
        check("rst_oe", 32'(sda_out_en), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_stb", 32'(wr_stb), 0);
        check("rst_idx", 32'(wr_idx), 0);
        check("rst_regs", reg_out, 32'h0);
        resetn = 1'b1;
        repeat (4) @(negedge clk);

        // Directed table
        for (int v = 0; v < 10; v++) begin
            stb_q.delete();
            exp_stb.delete();
            if (vec[v].nstb > 0) exp_stb.push_back(vec[v].stb[7:0]);
            if (vec[v].nstb > 1) exp_stb.push_back((v == 1) ? 8'h00 : vec[v].stb[15:8]);
            if (vec[v].kind == 0) begin
                do_write(vec[v].addr, vec[v].ptr, vec[v].n, vec[v].wd, aack, pack, dack, busy_a);
                check($sformatf("v%0d_addr_ack", v), 32'(aack), 32'(vec[v].aack));
                if (!aack) check($sformatf("v%0d_ptr_ack", v), 32'(pack), 32'(vec[v].pack));
                if (!aack && !pack) check($sformatf("v%0d_data_ack", v), 32'(dack), 0);
                if (aack) check($sformatf("v%0d_busy_nack", v), 32'(busy_a), 0);
            end else begin
                do_read(vec[v].kind == 1, vec[v].ptr, vec[v].n, acks, rd, oe_after);
                check($sformatf("v%0d_acks", v), 32'(acks), 0);
                check($sformatf("v%0d_rdata", v), rd, vec[v].rd);
                check($sformatf("v%0d_released", v), 32'(oe_after), 0);
            end
            check($sformatf("v%0d_regs", v), reg_out, vec[v].regs);
            compare_stb($sformatf("v%0d", v));
        end

        // Reset in the middle of a read while a 0 bit is being driven
        do_write(7'h33, 8'h03, 0, 0, aack, pack, dack, busy_a);
        check("mr_ptr_ack", 32'(pack), 0);
        i2c_start;
        send_byte(8'h67, ack);
        check("mr_addr_ack", 32'(ack), 0);
        sda_m = 1'b1;
        wait_q;
        check("mr_drive0", 32'(sda_out_en), 1);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        check("mr_oe_rst", 32'(sda_out_en), 0);
        check("mr_regs_rst", reg_out, 32'h0);
        check("mr_busy_rst", 32'(busy), 0);
        check("mr_idx_rst", 32'(wr_idx), 0);
        @(negedge clk);
        resetn = 1'b1;
        i2c_stop;
        stb_q.delete();
        exp_stb.delete();
        exp_stb.push_back(8'h01);
        do_write(7'h33, 8'h01, 1, 32'h77, aack, pack, dack, busy_a);
        check("mr_post_acks", 32'({aack, pack, dack}), 0);
        check("mr_post_regs", reg_out, 32'h00007700);
        compare_stb("mr_post");

        // One-clk SDA glitch while SCL is high during a data bit that is 0
        stb_q.delete();
        exp_stb.delete();
        i2c_start;
        send_byte(8'h66, aack);
        send_byte(8'h00, pack);
        check("gl_acks", 32'({aack, pack}), 0);
        sda_m = 1'b0; wait_q;
        scl = 1'b1;
        repeat (2) @(negedge clk);
        sda_m = 1'b1;
        @(negedge clk);
        sda_m = 1'b0;
        repeat (2*Q - 3) @(negedge clk);
        scl = 1'b0; wait_q;
        for (int i = 6; i >= 0; i--) xfer_bit(1'(i == 6), dummy);
        xfer_bit(1'b1, ack);
        busy_a = busy;
        i2c_stop;
`ifdef TWI_GLITCH_FILTER_EN
        exp_stb.push_back(8'h00);
        check("gl_data_ack", 32'(ack), 0);
        check("gl_busy", 32'(busy_a), 1);
        check("gl_regs", reg_out, 32'h00007740);
`else
        check("gl_data_ack", 32'(ack), 1);
        check("gl_busy", 32'(busy_a), 0);
        check("gl_regs", reg_out, 32'h00007700);
`endif
        compare_stb("gl");

        // Randomised transactions against a register model
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check("rr_idx_rst", 32'(wr_idx), 0);
        resetn = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
        m_ptr = 0;
        for (int t = 0; t < 14; t++) begin
            reg_in = $urandom;
            kind   = $urandom_range(0, 2);
            stb_q.delete();
            exp_stb.delete();
            if (kind == 0) begin
                p8 = 8'($urandom_range(0, 5));
                n  = $urandom_range(0, 3);
                d  = $urandom;
                do_write(7'h33, p8, n, d, aack, pack, dack, busy_a);
                check($sformatf("r%0d_addr_ack", t), 32'(aack), 0);
                check($sformatf("r%0d_ptr_ack", t), 32'(pack), 32'(p8 >= 8'd4));
                if (p8 < 8'd4) begin
                    m_ptr = int'(p8);
                    for (int i = 0; i < n; i++) begin
                        if (!RO[m_ptr]) begin
                            m_regs[m_ptr] = d[8*i +: 8];
                            exp_stb.push_back(8'(m_ptr));
                        end
                        m_ptr = (m_ptr + 1) % 4;
                    end
                    check($sformatf("r%0d_data_ack", t), 32'(dack), 0);
                end
            end else begin
                p8 = 8'($urandom_range(0, 3));
                n  = $urandom_range(1, 3);
                do_read(kind == 1, p8, n, acks, rd, oe_after);
                if (kind == 1) m_ptr = int'(p8);
                exp_rd = 32'd0;
                for (int i = 0; i < n; i++) begin
                    exp_rd[8*i +: 8] = RO[m_ptr] ? reg_in[8*m_ptr +: 8] : m_regs[m_ptr];
                    if (i < n - 1) m_ptr = (m_ptr + 1) % 4;
                end
                check($sformatf("r%0d_acks", t), 32'(acks), 0);
                check($sformatf("r%0d_rdata", t), rd, exp_rd);
                check($sformatf("r%0d_released", t), 32'(oe_after), 0);
            end
            check($sformatf("r%0d_regs", t), reg_out,
                  {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
            compare_stb($sformatf("r%0d", t));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
